bank_timing_array: RTL and testbench

- Parametrised successor to the per-bank DDR timing tracker.
- Holds one timed state machine per bank, selected by bank group and bank. Timing values sit in run-time-writable registers loaded by the memory controller.
- Adds enforcement of illegal commands (busy bank, tRAS violation, REF while banks open) and a tREFI refresh-due flag.
- Sits between the command decoder and the data-path/row-buffer logic of the memory emulator.

---
 rtl/bank_timing_pkg.sv | 78 +++++++
 rtl/bank_timing_array_fsm.sv | 134 +++++++++++++
 rtl/bank_timing_array.sv | 137 +++++++++++++
 tb/tb_bank_timing_array.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bank_timing_pkg.sv
// Shared types and constants for the per-bank DDR timing tracker array.
// Holds the bank state encoding, command/config indices, timing defaults and the timing bundle.
package bank_timing_pkg;

    typedef enum logic [3:0] {
        ST_IDLE        = 4'd0,
        ST_ACTIVATING  = 4'd1,
        ST_ACTIVE      = 4'd2,
        ST_READING     = 4'd3,
        ST_READ_AP     = 4'd4,
        ST_WRITING     = 4'd5,
        ST_WRITE_AP    = 4'd6,
        ST_PRECHARGING = 4'd7,
        ST_REFRESHING  = 4'd8
    } bank_state_e;

    localparam int CMD_W    = 19;
    localparam int CMD_ACT  = 18;
    localparam int CMD_BST  = 17;
    localparam int CMD_CFG  = 16;
    localparam int CMD_CKEH = 15;
    localparam int CMD_CKEL = 14;
    localparam int CMD_DPD  = 13;
    localparam int CMD_DPDX = 12;
    localparam int CMD_MRR  = 11;
    localparam int CMD_MRW  = 10;
    localparam int CMD_PD   = 9;
    localparam int CMD_PDX  = 8;
    localparam int CMD_PR   = 7;
    localparam int CMD_PRA  = 6;
    localparam int CMD_RD   = 5;
    localparam int CMD_RDA  = 4;
    localparam int CMD_REF  = 3;
    localparam int CMD_SRF  = 2;
    localparam int CMD_WR   = 1;
    localparam int CMD_WRA  = 0;

    // Commands that act on bank state; the rest pass through untouched.
    localparam logic [CMD_W-1:0] ACTION_MASK =
        (19'b1 << CMD_ACT) | (19'b1 << CMD_PR) | (19'b1 << CMD_PRA) | (19'b1 << CMD_RD) |
        (19'b1 << CMD_RDA) | (19'b1 << CMD_REF) | (19'b1 << CMD_WR) | (19'b1 << CMD_WRA);

    localparam int CFG_T_CL   = 0;
    localparam int CFG_T_RCD  = 1;
    localparam int CFG_T_RP   = 2;
    localparam int CFG_T_RFC  = 3;
    localparam int CFG_T_WR   = 4;
    localparam int CFG_T_RTP  = 5;
    localparam int CFG_T_CWL  = 6;
    localparam int CFG_T_RAS  = 7;
    localparam int CFG_T_REFI = 8;
    localparam int CFG_NUM    = 9;

    localparam logic [31:0] DEF_TIMING [0:CFG_NUM-1] = '{
        32'd17, 32'd17, 32'd17, 32'd34, 32'd14, 32'd7, 32'd10, 32'd32, 32'd9360
    };

    localparam int TIMING_W = 32;

    typedef struct packed {
        logic [TIMING_W-1:0] t_cl;
        logic [TIMING_W-1:0] t_rcd;
        logic [TIMING_W-1:0] t_rp;
        logic [TIMING_W-1:0] t_rfc;
        logic [TIMING_W-1:0] t_wr;
        logic [TIMING_W-1:0] t_rtp;
        logic [TIMING_W-1:0] t_cwl;
        logic [TIMING_W-1:0] t_ras;
    } timing_regs_t;

    // Wide enough that a three-term sum of timing fields can never wrap.
    function automatic logic [TIMING_W+1:0] dur_sum(input logic [TIMING_W-1:0] a,
                                                    input logic [TIMING_W-1:0] b,
                                                    input logic [TIMING_W-1:0] c);
        return {2'b00, a} + {2'b00, b} + {2'b00, c};
    endfunction

endpackage

// File: rtl/bank_timing_array_fsm.sv
// Timed state machine for a single DRAM bank plus its independent tRAS counter.
// Flags any addressed command the bank cannot take in its current state.
module bank_fsm
    import bank_timing_pkg::*;
#(
    parameter int BL     = 8,
    parameter int TWIDTH = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         act_i,
    input  logic         rd_i,
    input  logic         rda_i,
    input  logic         wr_i,
    input  logic         wra_i,
    input  logic         pr_i,
    input  logic         pra_go_i,
    input  logic         ref_go_i,
    input  timing_regs_t timing_i,
    output bank_state_e  state_o,
    output logic         ready_o,
    output logic         reject_o,
    output logic         pra_block_o
);

    localparam logic [TIMING_W+1:0] DMAX       = {{(TIMING_W+2-TWIDTH){1'b0}}, {TWIDTH{1'b1}}};
    localparam logic [TIMING_W-1:0] HALF_BURST = TIMING_W'(BL / 2);

    bank_state_e       state_q, state_d;
    logic [TWIDTH-1:0] cnt_q, cnt_d;
    logic [TWIDTH-1:0] ras_q, ras_d;
    logic              reject;
    logic              any_cmd;

    // Saturate to the counter range, treat zero as one cycle, then subtract the load cycle.
    function automatic logic [TWIDTH-1:0] load_of(input logic [TIMING_W+1:0] d);
        logic [TIMING_W+1:0] sat;
        sat = (d > DMAX) ? DMAX : d;
        if (sat == '0) begin
            sat = {{(TIMING_W+1){1'b0}}, 1'b1};
        end
        return TWIDTH'(sat - {{(TIMING_W+1){1'b0}}, 1'b1});
    endfunction

    logic [TWIDTH-1:0] ld_rcd, ld_rd, ld_rtp, ld_wr, ld_rp, ld_rfc, ld_ras;

    assign ld_rcd  = load_of({2'b00, timing_i.t_rcd});
    assign ld_rd   = load_of(dur_sum(timing_i.t_cl, HALF_BURST, '0));
    assign ld_rtp  = load_of({2'b00, timing_i.t_rtp});
    assign ld_wr   = load_of(dur_sum(timing_i.t_cwl, HALF_BURST, timing_i.t_wr));
    assign ld_rp   = load_of({2'b00, timing_i.t_rp});
    assign ld_rfc  = load_of({2'b00, timing_i.t_rfc});
    assign ld_ras  = load_of({2'b00, timing_i.t_ras});
    assign any_cmd = act_i | rd_i | rda_i | wr_i | wra_i | pr_i;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ras_d   = ras_q;
        reject  = 1'b0;
        if (ras_q != '0) begin
            ras_d = ras_q - 1'b1;
        end
        case (state_q)
            ST_IDLE: begin
                if (act_i) begin
                    state_d = ST_ACTIVATING;
                    cnt_d   = ld_rcd;
                    ras_d   = ld_ras;
                end else if (ref_go_i) begin
                    state_d = ST_REFRESHING;
                    cnt_d   = ld_rfc;
                end else if (rd_i || rda_i || wr_i || wra_i) begin
                    reject = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (rd_i) begin
                    state_d = ST_READING;
                    cnt_d   = ld_rd;
                end else if (rda_i) begin
                    state_d = ST_READ_AP;
                    cnt_d   = ld_rtp;
                end else if (wr_i) begin
                    state_d = ST_WRITING;
                    cnt_d   = ld_wr;
                end else if (wra_i) begin
                    state_d = ST_WRITE_AP;
                    cnt_d   = ld_wr;
                end else if ((pr_i && ras_q == '0) || pra_go_i) begin
                    state_d = ST_PRECHARGING;
                    cnt_d   = ld_rp;
                end else if (pr_i || act_i) begin
                    reject = 1'b1;
                end
            end
            ST_ACTIVATING, ST_READING, ST_READ_AP, ST_WRITING,
            ST_WRITE_AP, ST_PRECHARGING, ST_REFRESHING: begin
                reject = any_cmd;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    case (state_q)
                        ST_READ_AP, ST_WRITE_AP: begin
                            state_d = ST_PRECHARGING;
                            cnt_d   = ld_rp;
                        end
                        ST_PRECHARGING, ST_REFRESHING: state_d = ST_IDLE;
                        default:                       state_d = ST_ACTIVE;
                    endcase
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ras_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ras_q   <= ras_d;
        end
    end

    assign state_o     = state_q;
    assign ready_o     = (state_q == ST_IDLE) || (state_q == ST_ACTIVE);
    assign reject_o    = reject;
    assign pra_block_o = !ready_o || (state_q == ST_ACTIVE && ras_q != '0);

endmodule

// File: rtl/bank_timing_array.sv
// Array of per-bank timing trackers with run-time timing registers, broadcast
// PRA/REF legality, registered command-error pulse and tREFI refresh-due flag.
module bank_timing_array
    import bank_timing_pkg::*;
#(
    parameter int  BL      = 8,
    parameter int  BGWIDTH = 2,
    parameter int  BAWIDTH = 2,
    parameter int  USE_BG  = 1,
    parameter int  TWIDTH  = 16,
    localparam int NB      = ((USE_BG != 0) ? 2**BGWIDTH : 1) * 2**BAWIDTH
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [BGWIDTH-1:0]  bg,
    input  logic [BAWIDTH-1:0]  ba,
    input  logic [CMD_W-1:0]    commands,
    input  logic                cfg_we,
    input  logic [3:0]          cfg_addr,
    input  logic [TWIDTH-1:0]   cfg_wdata,
    output logic [NB*4-1:0]     bank_state,
    output logic [NB-1:0]       bank_ready,
    output logic                cmd_err,
    output logic                refresh_due
);

    localparam int NG  = (USE_BG != 0) ? 2**BGWIDTH : 1;
    localparam int NBA = 2**BAWIDTH;

    logic [TWIDTH-1:0] cfg_q [0:CFG_NUM-1];
    logic [TWIDTH-1:0] cfg_d [0:CFG_NUM-1];
    logic [TWIDTH-1:0] refresh_cnt_q, refresh_cnt_d;
    logic              refresh_due_q, refresh_due_d;
    logic              cmd_err_q, cmd_err_d;
    timing_regs_t      timing;
    logic              multi_cmd, single_cmd;
    logic              pra_req, pra_go, ref_req, ref_go;
    logic [NB-1:0]     bank_reject, bank_pra_block, bank_idle;

    always_comb begin
        for (int i = 0; i < CFG_NUM; i++) begin
            cfg_d[i] = cfg_q[i];
        end
        if (cfg_we && cfg_addr <= 4'(CFG_T_REFI)) begin
            cfg_d[cfg_addr] = cfg_wdata;
        end
    end

    assign timing.t_cl  = TIMING_W'(cfg_q[CFG_T_CL]);
    assign timing.t_rcd = TIMING_W'(cfg_q[CFG_T_RCD]);
    assign timing.t_rp  = TIMING_W'(cfg_q[CFG_T_RP]);
    assign timing.t_rfc = TIMING_W'(cfg_q[CFG_T_RFC]);
    assign timing.t_wr  = TIMING_W'(cfg_q[CFG_T_WR]);
    assign timing.t_rtp = TIMING_W'(cfg_q[CFG_T_RTP]);
    assign timing.t_cwl = TIMING_W'(cfg_q[CFG_T_CWL]);
    assign timing.t_ras = TIMING_W'(cfg_q[CFG_T_RAS]);

    // Ignored bits may coexist freely; a clash involving any state-changing bit is illegal.
    assign multi_cmd  = ($countones(commands) > 1) && (|(commands & ACTION_MASK));
    assign single_cmd = !multi_cmd;
    assign pra_req    = single_cmd && commands[CMD_PRA];
    assign ref_req    = single_cmd && commands[CMD_REF];
    assign pra_go     = pra_req && !(|bank_pra_block);
    assign ref_go     = ref_req && (&bank_idle);

    genvar g, b;
    generate
        for (g = 0; g < NG; g++) begin : gen_group
            for (b = 0; b < NBA; b++) begin : gen_bank
                localparam int IDX = g * NBA + b;
                logic        hit;
                bank_state_e st;

                assign hit = single_cmd && (ba == BAWIDTH'(b)) &&
                             ((USE_BG == 0) || (bg == BGWIDTH'(g)));

                bank_fsm #(
                    .BL     (BL),
                    .TWIDTH (TWIDTH)
                ) u_bank_fsm (
                    .clk         (clk),
                    .reset_n     (reset_n),
                    .act_i       (hit && commands[CMD_ACT]),
                    .rd_i        (hit && commands[CMD_RD]),
                    .rda_i       (hit && commands[CMD_RDA]),
                    .wr_i        (hit && commands[CMD_WR]),
                    .wra_i       (hit && commands[CMD_WRA]),
                    .pr_i        (hit && commands[CMD_PR]),
                    .pra_go_i    (pra_go),
                    .ref_go_i    (ref_go),
                    .timing_i    (timing),
                    .state_o     (st),
                    .ready_o     (bank_ready[IDX]),
                    .reject_o    (bank_reject[IDX]),
                    .pra_block_o (bank_pra_block[IDX])
                );

                assign bank_state[IDX*4 +: 4] = st;
                assign bank_idle[IDX]         = (st == ST_IDLE);
            end
        end
    endgenerate

    always_comb begin
        cmd_err_d     = multi_cmd || (|bank_reject) || (pra_req && !pra_go) || (ref_req && !ref_go);
        refresh_cnt_d = refresh_cnt_q;
        refresh_due_d = (refresh_cnt_q >= cfg_q[CFG_T_REFI]);
        if (ref_go) begin
            refresh_cnt_d = '0;
            refresh_due_d = 1'b0;
        end else if (refresh_cnt_q < cfg_q[CFG_T_REFI]) begin
            refresh_cnt_d = refresh_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < CFG_NUM; i++) begin
                cfg_q[i] <= TWIDTH'(DEF_TIMING[i]);
            end
            refresh_cnt_q <= '0;
            refresh_due_q <= 1'b0;
            cmd_err_q     <= 1'b0;
        end else begin
            for (int i = 0; i < CFG_NUM; i++) begin
                cfg_q[i] <= cfg_d[i];
            end
            refresh_cnt_q <= refresh_cnt_d;
            refresh_due_q <= refresh_due_d;
            cmd_err_q     <= cmd_err_d;
        end
    end

    assign cmd_err     = cmd_err_q;
    assign refresh_due = refresh_due_q;

endmodule

// File: tb/tb_bank_timing_array.sv
// Directed bench for bank_timing_array: a DDR4-style instance (16 banks) and a
// DDR3-style instance (USE_BG=0, BAWIDTH=3, 8 banks) sharing clock and reset.
module tb_bank_timing_array;

    localparam int C_ACT = 18, C_BST = 17, C_PR = 7, C_PRA = 6, C_RD = 5;
    localparam int C_RDA = 4, C_REF = 3, C_WR = 1, C_WRA = 0;
    localparam logic [3:0] S_IDLE = 4'd0, S_ACTIVATING = 4'd1, S_ACTIVE = 4'd2;
    localparam logic [3:0] S_READING = 4'd3, S_READ_AP = 4'd4, S_WRITING = 4'd5;
    localparam logic [3:0] S_WRITE_AP = 4'd6, S_PRECHARGING = 4'd7, S_REFRESHING = 4'd8;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  bg, bg_b;
    logic [1:0]  ba;
    logic [2:0]  ba_b;
    logic [18:0] commands, commands_b;
    logic        cfg_we, cfg_we_b;
    logic [3:0]  cfg_addr, cfg_addr_b;
    logic [15:0] cfg_wdata, cfg_wdata_b;
    logic [63:0] bank_state;
    logic [15:0] bank_ready;
    logic        cmd_err, refresh_due;
    logic [31:0] bank_state_b;
    logic [7:0]  bank_ready_b;
    logic        cmd_err_b, refresh_due_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bank_timing_array dut (
        .clk (clk), .reset_n (reset_n), .bg (bg), .ba (ba), .commands (commands),
        .cfg_we (cfg_we), .cfg_addr (cfg_addr), .cfg_wdata (cfg_wdata),
        .bank_state (bank_state), .bank_ready (bank_ready),
        .cmd_err (cmd_err), .refresh_due (refresh_due)
    );

    bank_timing_array #(.USE_BG(0), .BAWIDTH(3)) dut_b (
        .clk (clk), .reset_n (reset_n), .bg (bg_b), .ba (ba_b), .commands (commands_b),
        .cfg_we (cfg_we_b), .cfg_addr (cfg_addr_b), .cfg_wdata (cfg_wdata_b),
        .bank_state (bank_state_b), .bank_ready (bank_ready_b),
        .cmd_err (cmd_err_b), .refresh_due (refresh_due_b)
    );

    function automatic logic [3:0] st(input bit alt, input int idx);
        if (alt) return bank_state_b[idx*4 +: 4];
        return bank_state[idx*4 +: 4];
    endfunction

    function automatic logic [18:0] oh(input int c);
        return 19'b1 << c;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) tick();
    endtask

    task automatic issue(input bit alt, input logic [18:0] vec, input logic [1:0] g, input logic [2:0] b);
        if (alt) begin
            commands_b = vec; bg_b = g; ba_b = b;
        end else begin
            commands = vec; bg = g; ba = b[1:0];
        end
        tick();
        commands   = '0;
        commands_b = '0;
    endtask

    task automatic cfg_write(input logic [3:0] addr, input logic [15:0] data);
        cfg_we = 1'b1; cfg_addr = addr; cfg_wdata = data;
        tick();
        cfg_we = 1'b0;
    endtask

    // Counts the cycles state s stays visible, starting from the edge that entered it.
    task automatic measure(input bit alt, input int idx, input logic [3:0] s, output int cycles);
        cycles = 1;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (st(alt, idx) != s) break;
            cycles++;
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #2;
        n_checks++; if (bank_state !== 64'h0) begin n_fail++; $display("[TB] FAIL reset_state: got %h expected 0", bank_state); end
        n_checks++; if (bank_ready !== 16'hFFFF) begin n_fail++; $display("[TB] FAIL reset_ready: got %h expected ffff", bank_ready); end
        n_checks++; if (cmd_err !== 1'b0 || refresh_due !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_flags: got err=%b due=%b expected 0 0", cmd_err, refresh_due); end
        n_checks++; if (bank_state_b !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_state_b: got %h expected 0", bank_state_b); end
        do_reset();
    endtask

    task automatic test_reset_defaults();
        int cyc;
        logic [63:0] mask;
        mask = ~(64'hF << 24);
        issue(0, oh(C_ACT), 2'd1, 3'd2);
        n_checks++; if (st(0, 6) !== S_ACTIVATING) begin n_fail++; $display("[TB] FAIL act_b6_state: got %0d expected %0d", st(0, 6), S_ACTIVATING); end
        n_checks++; if ((bank_state & mask) !== 64'h0) begin n_fail++; $display("[TB] FAIL act_others_idle: got %h expected 0", bank_state & mask); end
        measure(0, 6, S_ACTIVATING, cyc);
        n_checks++; if (cyc !== 17) begin n_fail++; $display("[TB] FAIL trcd_default: got %0d expected 17", cyc); end
        n_checks++; if (st(0, 6) !== S_ACTIVE) begin n_fail++; $display("[TB] FAIL act_b6_active: got %0d expected %0d", st(0, 6), S_ACTIVE); end
        n_checks++; if (cmd_err !== 1'b0) begin n_fail++; $display("[TB] FAIL act_no_err: got %b expected 0", cmd_err); end
    endtask

    task automatic test_tras_guard();
        int cyc;
        issue(0, oh(C_ACT), 2'd0, 3'd0);
        wait_cycles(19);
        issue(0, oh(C_PR), 2'd0, 3'd0);
        n_checks++; if (cmd_err !== 1'b1) begin n_fail++; $display("[TB] FAIL tras_early_err: got %b expected 1", cmd_err); end
        n_checks++; if (st(0, 0) !== S_ACTIVE) begin n_fail++; $display("[TB] FAIL tras_early_state: got %0d expected %0d", st(0, 0), S_ACTIVE); end
        tick();
        n_checks++; if (cmd_err !== 1'b0) begin n_fail++; $display("[TB] FAIL err_one_cycle: got %b expected 0", cmd_err); end
        wait_cycles(9);
        issue(0, oh(C_PR), 2'd0, 3'd0);
        n_checks++; if (cmd_err !== 1'b1) begin n_fail++; $display("[TB] FAIL tras_edge31_err: got %b expected 1", cmd_err); end
        issue(0, oh(C_PR), 2'd0, 3'd0);
        n_checks++; if (st(0, 0) !== S_PRECHARGING || cmd_err !== 1'b0) begin n_fail++; $display("[TB] FAIL tras_edge32: got state=%0d err=%b expected 7 0", st(0, 0), cmd_err); end
        measure(0, 0, S_PRECHARGING, cyc);
        n_checks++; if (cyc !== 17) begin n_fail++; $display("[TB] FAIL trp_default: got %0d expected 17", cyc); end
        n_checks++; if (st(0, 0) !== S_IDLE) begin n_fail++; $display("[TB] FAIL pr_to_idle: got %0d expected 0", st(0, 0)); end
    endtask

    task automatic test_auto_precharge();
        int cyc;
        issue(0, oh(C_ACT), 2'd1, 3'd1);
        measure(0, 5, S_ACTIVATING, cyc);
        issue(0, oh(C_RD), 2'd1, 3'd1);
        measure(0, 5, S_READING, cyc);
        n_checks++; if (cyc !== 21) begin n_fail++; $display("[TB] FAIL reading_len: got %0d expected 21", cyc); end
        n_checks++; if (st(0, 5) !== S_ACTIVE) begin n_fail++; $display("[TB] FAIL rd_back_active: got %0d expected 2", st(0, 5)); end
        issue(0, oh(C_RDA), 2'd1, 3'd1);
        measure(0, 5, S_READ_AP, cyc);
        n_checks++; if (cyc !== 7) begin n_fail++; $display("[TB] FAIL read_ap_len: got %0d expected 7", cyc); end
        measure(0, 5, S_PRECHARGING, cyc);
        n_checks++; if (cyc !== 17 || st(0, 5) !== S_IDLE) begin n_fail++; $display("[TB] FAIL rda_pre: got len=%0d state=%0d expected 17 0", cyc, st(0, 5)); end
        issue(0, oh(C_ACT), 2'd1, 3'd1);
        measure(0, 5, S_ACTIVATING, cyc);
        issue(0, oh(C_WR), 2'd1, 3'd1);
        measure(0, 5, S_WRITING, cyc);
        n_checks++; if (cyc !== 28 || st(0, 5) !== S_ACTIVE) begin n_fail++; $display("[TB] FAIL writing: got len=%0d state=%0d expected 28 2", cyc, st(0, 5)); end
        issue(0, oh(C_WRA), 2'd1, 3'd1);
        measure(0, 5, S_WRITE_AP, cyc);
        n_checks++; if (cyc !== 28) begin n_fail++; $display("[TB] FAIL write_ap_len: got %0d expected 28", cyc); end
        n_checks++; if (st(0, 5) !== S_PRECHARGING) begin n_fail++; $display("[TB] FAIL wra_pre: got %0d expected 7", st(0, 5)); end
        measure(0, 5, S_PRECHARGING, cyc);
        n_checks++; if (st(0, 5) !== S_IDLE) begin n_fail++; $display("[TB] FAIL wra_idle: got %0d expected 0", st(0, 5)); end
    endtask

    task automatic test_config();
        int cyc;
        cfg_we = 1'b1; cfg_addr = 4'd1; cfg_wdata = 16'd5;
        commands = oh(C_ACT); bg = 2'd2; ba = 2'd0;
        tick();
        cfg_we = 1'b0; commands = '0;
        measure(0, 8, S_ACTIVATING, cyc);
        n_checks++; if (cyc !== 17) begin n_fail++; $display("[TB] FAIL cfg_same_cycle: got %0d expected 17", cyc); end
        issue(0, oh(C_ACT), 2'd2, 3'd1);
        measure(0, 9, S_ACTIVATING, cyc);
        n_checks++; if (cyc !== 5) begin n_fail++; $display("[TB] FAIL cfg_trcd5: got %0d expected 5", cyc); end
        cfg_write(4'd1, 16'd0);
        issue(0, oh(C_ACT), 2'd2, 3'd2);
        measure(0, 10, S_ACTIVATING, cyc);
        n_checks++; if (cyc !== 1 || st(0, 10) !== S_ACTIVE) begin n_fail++; $display("[TB] FAIL cfg_trcd0: got len=%0d state=%0d expected 1 2", cyc, st(0, 10)); end
        cfg_write(4'd1, 16'd17);
        issue(0, oh(C_ACT), 2'd3, 3'd0);
        issue(0, oh(C_PRA), 2'd0, 3'd0);
        n_checks++; if (cmd_err !== 1'b1 || st(0, 9) !== S_ACTIVE) begin n_fail++; $display("[TB] FAIL pra_busy: got err=%b b9=%0d expected 1 2", cmd_err, st(0, 9)); end
        wait_cycles(40);
        issue(0, oh(C_PRA), 2'd0, 3'd0);
        n_checks++; if (bank_state !== 64'h0007_0777_0700_0000) begin n_fail++; $display("[TB] FAIL pra_all: got %h expected 0007077707000000", bank_state); end
        n_checks++; if (cmd_err !== 1'b0) begin n_fail++; $display("[TB] FAIL pra_no_err: got %b expected 0", cmd_err); end
        measure(0, 8, S_PRECHARGING, cyc);
        n_checks++; if (cyc !== 17 || bank_state !== 64'h0) begin n_fail++; $display("[TB] FAIL pra_done: got len=%0d state=%h expected 17 0", cyc, bank_state); end
    endtask

    task automatic test_reject();
        int cyc;
        issue(0, oh(C_RD), 2'd0, 3'd1);
        n_checks++; if (cmd_err !== 1'b1 || st(0, 1) !== S_IDLE) begin n_fail++; $display("[TB] FAIL rd_idle: got err=%b state=%0d expected 1 0", cmd_err, st(0, 1)); end
        issue(0, oh(C_ACT), 2'd0, 3'd1);
        issue(0, oh(C_RD), 2'd0, 3'd1);
        n_checks++; if (cmd_err !== 1'b1 || st(0, 1) !== S_ACTIVATING) begin n_fail++; $display("[TB] FAIL rd_timed: got err=%b state=%0d expected 1 1", cmd_err, st(0, 1)); end
        measure(0, 1, S_ACTIVATING, cyc);
        issue(0, oh(C_ACT), 2'd0, 3'd1);
        n_checks++; if (cmd_err !== 1'b1 || st(0, 1) !== S_ACTIVE) begin n_fail++; $display("[TB] FAIL act_active: got err=%b state=%0d expected 1 2", cmd_err, st(0, 1)); end
        issue(0, oh(C_BST), 2'd0, 3'd1);
        n_checks++; if (cmd_err !== 1'b0) begin n_fail++; $display("[TB] FAIL bst_ignored: got %b expected 0", cmd_err); end
        issue(0, oh(C_PR), 2'd0, 3'd2);
        n_checks++; if (cmd_err !== 1'b0 || st(0, 2) !== S_IDLE) begin n_fail++; $display("[TB] FAIL pr_idle_noop: got err=%b state=%0d expected 0 0", cmd_err, st(0, 2)); end
    endtask

    task automatic test_refresh();
        int cyc;
        do_reset();
        cfg_write(4'd8, 16'd100);
        wait_cycles(99);
        n_checks++; if (refresh_due !== 1'b0) begin n_fail++; $display("[TB] FAIL refi_edge100: got %b expected 0", refresh_due); end
        tick();
        n_checks++; if (refresh_due !== 1'b1) begin n_fail++; $display("[TB] FAIL refi_edge101: got %b expected 1", refresh_due); end
        issue(0, oh(C_ACT), 2'd1, 3'd3);
        measure(0, 7, S_ACTIVATING, cyc);
        issue(0, oh(C_REF), 2'd0, 3'd0);
        n_checks++; if (cmd_err !== 1'b1 || bank_state !== 64'h2000_0000) begin n_fail++; $display("[TB] FAIL ref_open: got err=%b state=%h expected 1 20000000", cmd_err, bank_state); end
        wait_cycles(20);
        issue(0, oh(C_PR), 2'd1, 3'd3);
        measure(0, 7, S_PRECHARGING, cyc);
        n_checks++; if (refresh_due !== 1'b1) begin n_fail++; $display("[TB] FAIL due_held: got %b expected 1", refresh_due); end
        issue(0, oh(C_REF), 2'd0, 3'd0);
        n_checks++; if (bank_state !== {16{4'h8}}) begin n_fail++; $display("[TB] FAIL ref_all: got %h expected 8888888888888888", bank_state); end
        n_checks++; if (refresh_due !== 1'b0 || cmd_err !== 1'b0) begin n_fail++; $display("[TB] FAIL ref_flags: got due=%b err=%b expected 0 0", refresh_due, cmd_err); end
        measure(0, 0, S_REFRESHING, cyc);
        n_checks++; if (cyc !== 34 || bank_state !== 64'h0) begin n_fail++; $display("[TB] FAIL trfc: got len=%0d state=%h expected 34 0", cyc, bank_state); end
    endtask

    task automatic test_async_reset();
        int cyc;
        cfg_write(4'd1, 16'd5);
        issue(0, oh(C_ACT), 2'd0, 3'd3);
        wait_cycles(2);
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++; if (bank_state !== 64'h0) begin n_fail++; $display("[TB] FAIL async_reset: got %h expected 0", bank_state); end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        issue(0, oh(C_ACT), 2'd0, 3'd3);
        measure(0, 3, S_ACTIVATING, cyc);
        n_checks++; if (cyc !== 17) begin n_fail++; $display("[TB] FAIL cfg_after_reset: got %0d expected 17", cyc); end
    endtask

    task automatic test_use_bg0();
        int cyc;
        issue(1, oh(C_ACT), 2'd3, 3'd5);
        n_checks++; if (bank_state_b !== 32'h0010_0000) begin n_fail++; $display("[TB] FAIL bg0_act: got %h expected 00100000", bank_state_b); end
        measure(1, 5, S_ACTIVATING, cyc);
        n_checks++; if (cyc !== 17) begin n_fail++; $display("[TB] FAIL bg0_trcd: got %0d expected 17", cyc); end
        issue(1, oh(C_RD), 2'd1, 3'd5);
        n_checks++; if (st(1, 5) !== S_READING) begin n_fail++; $display("[TB] FAIL bg0_rd: got %0d expected 3", st(1, 5)); end
        issue(1, oh(C_ACT) | oh(C_RD), 2'd0, 3'd2);
        n_checks++; if (cmd_err_b !== 1'b1 || bank_state_b !== 32'h0030_0000) begin n_fail++; $display("[TB] FAIL multi_cmd: got err=%b state=%h expected 1 00300000", cmd_err_b, bank_state_b); end
        issue(1, oh(C_ACT), 2'd2, 3'd7);
        n_checks++; if (st(1, 7) !== S_ACTIVATING || cmd_err_b !== 1'b0) begin n_fail++; $display("[TB] FAIL bg0_top_bank: got state=%0d err=%b expected 1 0", st(1, 7), cmd_err_b); end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset_n = 1'b0;
        bg = '0; ba = '0; commands = '0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        bg_b = '0; ba_b = '0; commands_b = '0; cfg_we_b = 1'b0; cfg_addr_b = '0; cfg_wdata_b = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_reset_defaults();
        test_tras_guard();
        test_auto_precharge();
        test_config();
        test_reject();
        test_refresh();
        test_async_reset();
        test_use_bg0();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
